bitbuf_sched: RTL and testbench

Scheduler and arbiter in front of the entropy-stage bit buffer (16-bit data, 8-bit length, w_en/r_en/wait/busy interface). It shares the buffer between two requesters: A, the Huffman/entropy coder codes, and B, the header/marker words. It paces writes against the buffer's busy and latency rules. It byte-aligns the stream before any B word, and issues the end-of-scan flush.

---
 rtl/bitbuf_sched.sv | 141 ++++++++++++++
 tb/tb_bitbuf_sched.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitbuf_sched.sv
// Arbitrates coder (A) and header (B) words into the entropy bit buffer, pacing
// writes around the buffer's busy latency, byte-aligning before B and flushing at end of scan.
module bitbuf_sched #(
    parameter int LEN_W   = 5,
    parameter bit B_ALIGN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wait,
    input  logic             i_a_valid,
    input  logic [15:0]      i_a_data,
    input  logic [LEN_W-1:0] i_a_len,
    input  logic             i_a_last,
    output logic             o_a_ready,
    input  logic             i_b_valid,
    input  logic [15:0]      i_b_data,
    input  logic [LEN_W-1:0] i_b_len,
    output logic             o_b_ready,
    input  logic             i_bb_busy,
    output logic             o_bb_w_en,
    output logic [15:0]      o_bb_data,
    output logic [7:0]       o_bb_datalength,
    output logic             o_bb_r_en,
    output logic             o_bb_wait,
    output logic             o_eos,
    output logic             o_idle
);

    typedef enum logic [2:0] {IDLE, ISSUE, GUARD, DRAIN, FLUSH, FGAP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        pend_last_q, pend_last_d;
    logic [15:0] data_q, data_d;
    logic [7:0]  len_q, len_d;
    logic        a_ready, b_ready;
    logic [4:0]  a_len_sat, b_len_sat;

    function automatic logic [4:0] sat_len(input logic [LEN_W-1:0] l);
        if (32'(l) > 32'd16)
            return 5'd16;
        return 5'(l);
    endfunction

    function automatic logic [15:0] mask_data(input logic [15:0] d, input logic [4:0] n);
        logic [16:0] m;
        m = (17'd1 << n) - 17'd1;
        return d & m[15:0];
    endfunction

    assign a_len_sat = sat_len(i_a_len);
    assign b_len_sat = sat_len(i_b_len);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        pend_last_d = pend_last_q;
        data_d      = data_q;
        len_d       = len_q;
        a_ready     = 1'b0;
        b_ready     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_b_valid) begin
                    if (bit_cnt_q == 3'd0 || !B_ALIGN) begin
                        b_ready   = 1'b1;
                        data_d    = mask_data(i_b_data, b_len_sat);
                        len_d     = {3'b000, b_len_sat};
                        bit_cnt_d = bit_cnt_q + b_len_sat[2:0];
                        state_d   = (b_len_sat == 5'd0) ? DRAIN : ISSUE;
                    end else if (!i_bb_busy) begin
                        // Alignment flush first; B is re-arbitrated on return to IDLE.
                        state_d = FLUSH;
                    end
                end else if (i_a_valid) begin
                    a_ready     = 1'b1;
                    pend_last_d = i_a_last;
                    data_d      = mask_data(i_a_data, a_len_sat);
                    len_d       = {3'b000, a_len_sat};
                    bit_cnt_d   = bit_cnt_q + a_len_sat[2:0];
                    state_d     = (a_len_sat == 5'd0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: state_d = GUARD;
            GUARD: state_d = DRAIN;
            DRAIN: begin
                if (!i_bb_busy)
                    state_d = pend_last_q ? FLUSH : IDLE;
            end
            FLUSH: begin
                bit_cnt_d = 3'd0;
                state_d   = FGAP;
            end
            FGAP: begin
                pend_last_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A downstream stall freezes everything, including the handshake.
        if (i_wait) begin
            state_d     = state_q;
            bit_cnt_d   = bit_cnt_q;
            pend_last_d = pend_last_q;
            data_d      = data_q;
            len_d       = len_q;
            a_ready     = 1'b0;
            b_ready     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            pend_last_q <= 1'b0;
            data_q      <= 16'd0;
            len_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            pend_last_q <= pend_last_d;
            data_q      <= data_d;
            len_q       <= len_d;
        end
    end

    assign o_a_ready       = a_ready;
    assign o_b_ready       = b_ready;
    assign o_bb_w_en       = (state_q == ISSUE);
    assign o_bb_data       = data_q;
    assign o_bb_datalength = len_q;
    assign o_bb_r_en       = (state_q == FLUSH) && (bit_cnt_q != 3'd0);
    assign o_bb_wait       = i_wait;
    // pend_last is only ever set while a last word is in flight, so it marks the end-of-scan flush.
    assign o_eos           = (state_q == FGAP) && pend_last_q;
    assign o_idle          = (state_q == IDLE) && !i_a_valid && !i_b_valid;

endmodule

// File: tb/tb_bitbuf_sched.sv
// Directed bench for bitbuf_sched: one aligned instance (main) and one without
// B alignment (n_ prefix), checked against hand-computed values.
module tb_bitbuf_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        i_wait, a_valid, a_last, b_valid, bb_busy;
    logic [15:0] a_data, b_data;
    logic [4:0]  a_len, b_len;
    logic        a_ready, b_ready, w_en, r_en, bb_wait, eos, idle;
    logic [15:0] bb_data;
    logic [7:0]  bb_len;

    logic        n_wait, n_a_valid, n_a_last, n_b_valid, n_bb_busy;
    logic [15:0] n_a_data, n_b_data;
    logic [4:0]  n_a_len, n_b_len;
    logic        n_a_ready, n_b_ready, n_w_en, n_r_en, n_bb_wait, n_eos, n_idle;
    logic [15:0] n_bb_data;
    logic [7:0]  n_bb_len;

    bitbuf_sched #(.LEN_W(5), .B_ALIGN(1'b1)) dut (
        .clk(clk), .rst(rst), .i_wait(i_wait),
        .i_a_valid(a_valid), .i_a_data(a_data), .i_a_len(a_len), .i_a_last(a_last),
        .o_a_ready(a_ready),
        .i_b_valid(b_valid), .i_b_data(b_data), .i_b_len(b_len), .o_b_ready(b_ready),
        .i_bb_busy(bb_busy), .o_bb_w_en(w_en), .o_bb_data(bb_data),
        .o_bb_datalength(bb_len), .o_bb_r_en(r_en), .o_bb_wait(bb_wait),
        .o_eos(eos), .o_idle(idle)
    );

    bitbuf_sched #(.LEN_W(5), .B_ALIGN(1'b0)) dut_na (
        .clk(clk), .rst(rst), .i_wait(n_wait),
        .i_a_valid(n_a_valid), .i_a_data(n_a_data), .i_a_len(n_a_len), .i_a_last(n_a_last),
        .o_a_ready(n_a_ready),
        .i_b_valid(n_b_valid), .i_b_data(n_b_data), .i_b_len(n_b_len), .o_b_ready(n_b_ready),
        .i_bb_busy(n_bb_busy), .o_bb_w_en(n_w_en), .o_bb_data(n_bb_data),
        .o_bb_datalength(n_bb_len), .o_bb_r_en(n_r_en), .o_bb_wait(n_bb_wait),
        .o_eos(n_eos), .o_idle(n_idle)
    );

    int vectors = 0;
    int miscompares = 0;
    int w_cnt = 0, r_cnt = 0, eos_cnt = 0, n_r_cnt = 0, hazard = 0;
    logic prev_w = 1'b0;

    // Pulse counters plus strobe-hazard detection (overlap, r_en after w_en, strobe while busy).
    always @(posedge clk) begin
        if (!rst && !i_wait) begin
            if (w_en) w_cnt++;
            if (r_en) r_cnt++;
            if (eos) eos_cnt++;
            if (r_en && (w_en || prev_w || bb_busy)) hazard++;
            if (w_en && bb_busy) hazard++;
            prev_w = w_en;
        end
        if (!rst && !n_wait && n_r_en) n_r_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_wait = 0; a_valid = 0; a_data = 0; a_len = 0; a_last = 0;
        b_valid = 0; b_data = 0; b_len = 0; bb_busy = 0;
        n_wait = 0; n_a_valid = 0; n_a_data = 0; n_a_len = 0; n_a_last = 0;
        n_b_valid = 0; n_b_data = 0; n_b_len = 0; n_bb_busy = 0;
        repeat (2) @(negedge clk);
        vectors++; if ({w_en, r_en, eos, bb_wait} !== 4'b0000) begin
            $display("FAIL reset_strobes: got %b want 0000", {w_en, r_en, eos, bb_wait}); miscompares++; end
        vectors++; if (bb_data !== 16'h0000 || bb_len !== 8'h00) begin
            $display("FAIL reset_data: got %h/%0d want 0000/0", bb_data, bb_len); miscompares++; end
        vectors++; if (idle !== 1'b1 || n_idle !== 1'b1) begin
            $display("FAIL reset_idle: got %b%b want 11", idle, n_idle); miscompares++; end
        rst = 1'b0;
        tick();
        $display("txn reset released");
    endtask

    task automatic test_a_pair();
        int w0, r0;
        w0 = w_cnt; r0 = r_cnt;
        a_valid = 1; a_data = 16'hFFF5; a_len = 5'd3; a_last = 0; #1;
        vectors++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            $display("FAIL pair_ready1: got a=%b b=%b want a=1 b=0", a_ready, b_ready); miscompares++; end
        tick(); a_valid = 0;
        $display("txn A len=3 data=fff5");
        vectors++; if (w_en !== 1'b1 || bb_data !== 16'h0005 || bb_len !== 8'd3) begin
            $display("FAIL pair_word1: got w=%b %h/%0d want 1 0005/3", w_en, bb_data, bb_len); miscompares++; end
        tick();
        vectors++; if (w_en !== 1'b0) begin
            $display("FAIL pair_guard: got w_en=%b want 0", w_en); miscompares++; end
        tick();
        a_valid = 1; a_data = 16'hABE3; a_len = 5'd5; #1;
        vectors++; if (a_ready !== 1'b0) begin
            $display("FAIL pair_drain_ready: got %b want 0", a_ready); miscompares++; end
        tick(); #1;
        vectors++; if (a_ready !== 1'b1) begin
            $display("FAIL pair_ready2: got %b want 1", a_ready); miscompares++; end
        tick(); a_valid = 0;
        $display("txn A len=5 data=abe3");
        vectors++; if (w_en !== 1'b1 || bb_data !== 16'h0003 || bb_len !== 8'd5) begin
            $display("FAIL pair_word2: got w=%b %h/%0d want 1 0003/5", w_en, bb_data, bb_len); miscompares++; end
        repeat (3) tick();
        vectors++; if (dut.bit_cnt_q !== 3'd0) begin
            $display("FAIL pair_bitcnt: got %0d want 0", dut.bit_cnt_q); miscompares++; end
        vectors++; if (w_cnt - w0 != 2 || r_cnt - r0 != 0) begin
            $display("FAIL pair_counts: got w=%0d r=%0d want 2 0", w_cnt - w0, r_cnt - r0); miscompares++; end
    endtask

    task automatic test_last_busy();
        int w0, r0, e0;
        w0 = w_cnt; r0 = r_cnt; e0 = eos_cnt;
        a_valid = 1; a_data = 16'h07FF; a_len = 5'd11; a_last = 1; #1;
        vectors++; if (a_ready !== 1'b1) begin
            $display("FAIL last_ready: got %b want 1", a_ready); miscompares++; end
        tick(); a_valid = 0; a_last = 0;
        $display("txn A len=11 data=07ff last");
        vectors++; if (w_en !== 1'b1 || bb_data !== 16'h07FF || bb_len !== 8'd11) begin
            $display("FAIL last_word: got w=%b %h/%0d want 1 07ff/11", w_en, bb_data, bb_len); miscompares++; end
        tick(); bb_busy = 1;
        tick();
        vectors++; if (r_en !== 1'b0 || dut.bit_cnt_q !== 3'd3) begin
            $display("FAIL last_busy1: got r=%b cnt=%0d want 0 3", r_en, dut.bit_cnt_q); miscompares++; end
        repeat (2) tick();
        vectors++; if (r_en !== 1'b0 || idle !== 1'b0 || eos !== 1'b0) begin
            $display("FAIL last_busy3: got r=%b idle=%b eos=%b want 0 0 0", r_en, idle, eos); miscompares++; end
        bb_busy = 0;
        tick();
        vectors++; if (r_en !== 1'b1 || eos !== 1'b0 || w_en !== 1'b0) begin
            $display("FAIL last_flush: got r=%b eos=%b w=%b want 1 0 0", r_en, eos, w_en); miscompares++; end
        tick();
        vectors++; if (r_en !== 1'b0 || eos !== 1'b1) begin
            $display("FAIL last_eos: got r=%b eos=%b want 0 1", r_en, eos); miscompares++; end
        tick();
        vectors++; if (eos !== 1'b0 || idle !== 1'b1 || dut.bit_cnt_q !== 3'd0) begin
            $display("FAIL last_end: got eos=%b idle=%b cnt=%0d want 0 1 0", eos, idle, dut.bit_cnt_q); miscompares++; end
        vectors++; if (w_cnt - w0 != 1 || r_cnt - r0 != 1 || eos_cnt - e0 != 1) begin
            $display("FAIL last_counts: got w=%0d r=%0d e=%0d want 1 1 1", w_cnt - w0, r_cnt - r0, eos_cnt - e0); miscompares++; end
    endtask

    task automatic test_align_b();
        int r0;
        a_valid = 1; a_data = 16'h001F; a_len = 5'd5; a_last = 0;
        tick(); a_valid = 0;
        $display("txn A len=5 data=001f");
        repeat (3) tick();
        vectors++; if (dut.bit_cnt_q !== 3'd5) begin
            $display("FAIL align_pre_cnt: got %0d want 5", dut.bit_cnt_q); miscompares++; end
        r0 = r_cnt;
        a_valid = 1; a_data = 16'h0003; a_len = 5'd8;
        b_valid = 1; b_data = 16'hFFD8; b_len = 5'd16; #1;
        vectors++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            $display("FAIL align_hold: got a=%b b=%b want 0 0", a_ready, b_ready); miscompares++; end
        tick();
        vectors++; if (r_en !== 1'b1 || w_en !== 1'b0 || b_ready !== 1'b0) begin
            $display("FAIL align_flush: got r=%b w=%b b=%b want 1 0 0", r_en, w_en, b_ready); miscompares++; end
        tick();
        vectors++; if (r_en !== 1'b0 || eos !== 1'b0) begin
            $display("FAIL align_fgap: got r=%b eos=%b want 0 0", r_en, eos); miscompares++; end
        tick(); #1;
        vectors++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
            $display("FAIL align_grant_b: got b=%b a=%b want 1 0", b_ready, a_ready); miscompares++; end
        tick(); b_valid = 0;
        $display("txn B len=16 data=ffd8");
        vectors++; if (w_en !== 1'b1 || bb_data !== 16'hFFD8 || bb_len !== 8'd16) begin
            $display("FAIL align_b_word: got w=%b %h/%0d want 1 ffd8/16", w_en, bb_data, bb_len); miscompares++; end
        repeat (3) tick(); #1;
        vectors++; if (a_ready !== 1'b1) begin
            $display("FAIL align_grant_a: got %b want 1", a_ready); miscompares++; end
        tick(); a_valid = 0;
        $display("txn A len=8 data=0003");
        vectors++; if (w_en !== 1'b1 || bb_data !== 16'h0003 || bb_len !== 8'd8) begin
            $display("FAIL align_a_word: got w=%b %h/%0d want 1 0003/8", w_en, bb_data, bb_len); miscompares++; end
        repeat (3) tick();
        vectors++; if (r_cnt - r0 != 1 || dut.bit_cnt_q !== 3'd0) begin
            $display("FAIL align_counts: got r=%0d cnt=%0d want 1 0", r_cnt - r0, dut.bit_cnt_q); miscompares++; end
    endtask

    task automatic test_no_align();
        n_a_valid = 1; n_a_data = 16'h0015; n_a_len = 5'd5; n_a_last = 0; #1;
        vectors++; if (n_a_ready !== 1'b1) begin
            $display("FAIL noalign_a_ready: got %b want 1", n_a_ready); miscompares++; end
        tick(); n_a_valid = 0;
        $display("txn nA len=5 data=0015");
        repeat (3) tick();
        n_b_valid = 1; n_b_data = 16'h1234; n_b_len = 5'd8; #1;
        vectors++; if (n_b_ready !== 1'b1) begin
            $display("FAIL noalign_b_ready: got %b want 1", n_b_ready); miscompares++; end
        tick(); n_b_valid = 0;
        $display("txn nB len=8 data=1234");
        vectors++; if (n_w_en !== 1'b1 || n_bb_data !== 16'h0034 || n_bb_len !== 8'd8 || n_r_en !== 1'b0) begin
            $display("FAIL noalign_word: got w=%b %h/%0d r=%b want 1 0034/8 0", n_w_en, n_bb_data, n_bb_len, n_r_en); miscompares++; end
        repeat (3) tick();
        vectors++; if (n_r_cnt != 0 || dut_na.bit_cnt_q !== 3'd5) begin
            $display("FAIL noalign_counts: got r=%0d cnt=%0d want 0 5", n_r_cnt, dut_na.bit_cnt_q); miscompares++; end
    endtask

    task automatic test_zero_len_last();
        int w0, r0, e0;
        w0 = w_cnt; r0 = r_cnt; e0 = eos_cnt;
        a_valid = 1; a_data = 16'hFFFF; a_len = 5'd0; a_last = 1; #1;
        vectors++; if (a_ready !== 1'b1) begin
            $display("FAIL zero_ready: got %b want 1", a_ready); miscompares++; end
        tick(); a_valid = 0; a_last = 0;
        $display("txn A len=0 last");
        vectors++; if (w_en !== 1'b0 || bb_len !== 8'd0 || bb_data !== 16'h0000) begin
            $display("FAIL zero_nowrite: got w=%b %h/%0d want 0 0000/0", w_en, bb_data, bb_len); miscompares++; end
        tick();
        vectors++; if (r_en !== 1'b0) begin
            $display("FAIL zero_no_ren: got %b want 0", r_en); miscompares++; end
        tick();
        vectors++; if (eos !== 1'b1) begin
            $display("FAIL zero_eos: got %b want 1", eos); miscompares++; end
        tick();
        vectors++; if (w_cnt - w0 != 0 || r_cnt - r0 != 0 || eos_cnt - e0 != 1 || idle !== 1'b1) begin
            $display("FAIL zero_counts: got w=%0d r=%0d e=%0d idle=%b want 0 0 1 1", w_cnt - w0, r_cnt - r0, eos_cnt - e0, idle); miscompares++; end
    endtask

    task automatic test_len_sat();
        a_valid = 1; a_data = 16'hABCD; a_len = 5'd20; a_last = 0; #1;
        vectors++; if (a_ready !== 1'b1) begin
            $display("FAIL sat_ready: got %b want 1", a_ready); miscompares++; end
        tick(); a_valid = 0;
        $display("txn A len=20 data=abcd");
        vectors++; if (w_en !== 1'b1 || bb_data !== 16'hABCD || bb_len !== 8'd16) begin
            $display("FAIL sat_word: got w=%b %h/%0d want 1 abcd/16", w_en, bb_data, bb_len); miscompares++; end
        repeat (3) tick();
        vectors++; if (dut.bit_cnt_q !== 3'd0) begin
            $display("FAIL sat_bitcnt: got %0d want 0", dut.bit_cnt_q); miscompares++; end
    endtask

    task automatic test_wait();
        int w0;
        a_valid = 1; a_data = 16'h00D5; a_len = 5'd7; a_last = 0;
        tick(); a_valid = 0;
        $display("txn A len=7 data=00d5");
        vectors++; if (w_en !== 1'b1 || bb_data !== 16'h0055 || bb_len !== 8'd7) begin
            $display("FAIL wait_word: got w=%b %h/%0d want 1 0055/7", w_en, bb_data, bb_len); miscompares++; end
        w0 = w_cnt;
        i_wait = 1; #1;
        vectors++; if (bb_wait !== 1'b1) begin
            $display("FAIL wait_pass: got %b want 1", bb_wait); miscompares++; end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++; if (w_en !== 1'b1 || bb_data !== 16'h0055 || bb_len !== 8'd7) begin
                $display("FAIL wait_issue_hold%0d: got w=%b %h/%0d want 1 0055/7", i, w_en, bb_data, bb_len); miscompares++; end
        end
        i_wait = 0;
        tick();
        vectors++; if (w_en !== 1'b0 || w_cnt - w0 != 1) begin
            $display("FAIL wait_issue_once: got w=%b n=%0d want 0 1", w_en, w_cnt - w0); miscompares++; end
        tick(); i_wait = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++; if (idle !== 1'b0 || w_en !== 1'b0 || bb_wait !== 1'b1) begin
                $display("FAIL wait_drain_hold%0d: got idle=%b w=%b wait=%b want 0 0 1", i, idle, w_en, bb_wait); miscompares++; end
        end
        i_wait = 0;
        tick();
        vectors++; if (idle !== 1'b1) begin
            $display("FAIL wait_resume: got idle=%b want 1", idle); miscompares++; end
        i_wait = 1; a_valid = 1; a_data = 16'h0001; a_len = 5'd1; #1;
        vectors++; if (a_ready !== 1'b0) begin
            $display("FAIL wait_ready_gate: got %b want 0", a_ready); miscompares++; end
        tick();
        vectors++; if (w_en !== 1'b0 || dut.bit_cnt_q !== 3'd7) begin
            $display("FAIL wait_no_accept: got w=%b cnt=%0d want 0 7", w_en, dut.bit_cnt_q); miscompares++; end
        a_valid = 0; i_wait = 0;
    endtask

    task automatic test_reset_mid();
        int e0;
        e0 = eos_cnt;
        a_valid = 1; a_data = 16'h0001; a_len = 5'd2; a_last = 1;
        tick(); a_valid = 0; a_last = 0;
        $display("txn A len=2 data=0001 last (reset in flight)");
        rst = 1; #1;
        vectors++; if (w_en !== 1'b0 || idle !== 1'b1 || bb_len !== 8'd0 || bb_data !== 16'h0000) begin
            $display("FAIL midreset_clear: got w=%b idle=%b %h/%0d want 0 1 0000/0", w_en, idle, bb_data, bb_len); miscompares++; end
        tick(); rst = 0;
        b_valid = 1; b_data = 16'h00AA; b_len = 5'd8; #1;
        vectors++; if (b_ready !== 1'b1) begin
            $display("FAIL midreset_b_ready: got %b want 1", b_ready); miscompares++; end
        tick(); b_valid = 0;
        $display("txn B len=8 data=00aa");
        vectors++; if (w_en !== 1'b1 || bb_data !== 16'h00AA || bb_len !== 8'd8) begin
            $display("FAIL midreset_word: got w=%b %h/%0d want 1 00aa/8", w_en, bb_data, bb_len); miscompares++; end
        repeat (4) tick();
        vectors++; if (eos_cnt - e0 != 0 || idle !== 1'b1) begin
            $display("FAIL midreset_no_eos: got e=%0d idle=%b want 0 1", eos_cnt - e0, idle); miscompares++; end
    endtask

    initial begin
        test_reset();
        test_a_pair();
        test_last_busy();
        test_align_b();
        test_no_align();
        test_zero_len_last();
        test_len_sat();
        test_wait();
        test_reset_mid();
        vectors++; if (hazard != 0) begin
            $display("FAIL strobe_hazard: got %0d want 0", hazard); miscompares++; end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
